// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block width and round-datapath channel indices
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int CH_LOAD = 0;
  localparam int CH_ROUND = 1;
  localparam int CH_KEY = 2;
endpackage

// File: rtl/aes_state_sel_if.sv
// aes_state_sel_if: N input channels plus one registered output, grouped as a bus
interface aes_state_sel_if #(
  parameter int WIDTH = aes_pkg::AES_BLOCK_W,
  parameter int N = 2
);
  localparam int SEL_W = $clog2(N);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_chan;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, sel, out_ready, input in_ready, out_data, out_chan, out_valid);
  modport slave(input in_data, in_valid, sel, out_ready, output in_ready, out_data, out_chan, out_valid);
endinterface

// File: rtl/aes_state_sel_arb.sv
// aes_rr_arb: round-robin grant searching from ptr+1 upward, wrapping modulo N
module aes_rr_arb #(
  parameter int N = 2,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             advance_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             grant_vld_o,
  output logic [SEL_W-1:0] ptr_nxt_o
);
  // scan farthest-first so the nearest requester after ptr wins
  always_comb begin
    grant_o = '0;
    grant_vld_o = 1'b0;
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_o = SEL_W'((int'(ptr_i) + k) % N);
        grant_vld_o = 1'b1;
      end
  end
  assign ptr_nxt_o = advance_i ? grant_o : ptr_i;
endmodule

// File: rtl/aes_state_sel.sv
// aes_state_sel: N:1 registered selector, explicit select or round-robin (AES_STATE_SEL_RR_EN)
module aes_state_sel import aes_pkg::*; #(
  parameter int WIDTH = AES_BLOCK_W,
  parameter int N = 2
) (
  input logic clk,
  input logic rst,
  aes_state_sel_if.slave bus
);
  localparam int SEL_W = $clog2(N);
  logic [SEL_W-1:0] g;
  logic gv, load_ok, xfer;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic out_valid_q, out_valid_d;
  assign load_ok = !out_valid_q || bus.out_ready;
`ifdef AES_STATE_SEL_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  aes_rr_arb #(.N(N)) u_arb (
    .req_i(bus.in_valid),
    .ptr_i(ptr_q),
    .advance_i(xfer),
    .grant_o(g),
    .grant_vld_o(gv),
    .ptr_nxt_o(ptr_d)
  );
  // pointer moves to the winner only when its word is actually taken
  always_ff @(posedge clk) ptr_q <= rst ? SEL_W'(N - 1) : ptr_d;
`else
  assign g = bus.sel;
  assign gv = 32'(bus.sel) < N;
`endif
  assign bus.in_ready = (!rst && load_ok && gv) ? (N'(1) << g) : '0;
  assign xfer = |(bus.in_valid & bus.in_ready);
  // load on transfer, drop valid on a plain consume, otherwise hold
  always_comb begin
    out_data_d = xfer ? bus.in_data[g*WIDTH +: WIDTH] : out_data_q;
    out_chan_d = xfer ? g : out_chan_q;
    out_valid_d = xfer || (out_valid_q && !bus.out_ready);
  end
  // output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_chan_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.out_data = out_data_q;
  assign bus.out_chan = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_aes_state_sel.sv
// tb_aes_state_sel: random + directed stimulus, queue scoreboard against a grant-rule model
module tb_aes_state_sel;
  import aes_pkg::*;
  localparam int W = AES_BLOCK_W;
  localparam int N = 3;
  localparam int SW = $clog2(N);
  localparam int CW = W + 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes_state_sel_if #(.WIDTH(W), .N(N)) bus ();
  aes_state_sel #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [W-1:0] d; logic [SW-1:0] c;} exp_t;
  exp_t q[$];
  logic [W-1:0] dat [N];
  int n_cmp = 0;
  int n_bad = 0;
  bit mv = 1'b0;
  int ptr = N - 1;
  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // grant rule: explicit select if in range, or first valid channel after the last winner
  function automatic int grant(input logic [N-1:0] v, input int s);
`ifdef AES_STATE_SEL_RR_EN
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
`else
    return (s < N) ? s : -1;
`endif
  endfunction
  task automatic step(input logic [N-1:0] v, input int s, input bit r);
    int g;
    logic [N-1:0] er;
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.sel = SW'(s);
    bus.out_ready = r;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = dat[i];
    #1;
    g = grant(v, s);
    er = '0;
    if (g >= 0 && (!mv || r)) er[g] = 1'b1;
    chk("in_ready", CW'(bus.in_ready), CW'(er));
    chk("out_valid", CW'(bus.out_valid), CW'(mv));
    if (g >= 0 && er[g] && v[g]) begin
      q.push_back('{dat[g], SW'(g)});
      mv = 1'b1;
      ptr = g;
    end else if (r) mv = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", CW'(bus.in_ready), CW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = '0;
    q.delete();
    mv = 1'b0;
    ptr = N - 1;
    #1;
    chk("rst_valid", CW'(bus.out_valid), CW'(0));
    chk("rst_data", CW'(bus.out_data), CW'(0));
    chk("rst_chan", CW'(bus.out_chan), CW'(0));
  endtask
  // monitor: every cycle the register is valid it must show the oldest unconsumed word
  always @(negedge clk)
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_word: got unexpected word %h want none", bus.out_data);
      end else begin
        chk("out_data", CW'(bus.out_data), CW'(q[0].d));
        chk("out_chan", CW'(bus.out_chan), CW'(q[0].c));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  initial begin
    bus.in_valid = '0;
    bus.sel = '0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("init_valid", CW'(bus.out_valid), CW'(0));
    chk("init_data", CW'(bus.out_data), CW'(0));
    chk("init_chan", CW'(bus.out_chan), CW'(0));
    dat[0] = W'(1);
    dat[1] = '1;
    dat[2] = W'(3);
    step(3'b011, 1, 1'b1);
    step(3'b000, 0, 1'b1);
    dat[0] = W'(5);
    step(3'b001, 0, 1'b0);
    dat[0] = W'(6);
    repeat (5) step(3'b001, 0, 1'b0);
    step(3'b001, 0, 1'b1);
    step(3'b000, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      dat[0] = W'(k);
      step(3'b001, 0, 1'b1);
    end
    step(3'b000, 0, 1'b1);
    for (int k = 0; k < 6; k++) step(3'b111, k % N, 1'b1);
    for (int k = 0; k < 4; k++) step(3'b101, 2 * (k % 2), 1'b1);
    step(3'b111, 3, 1'b1);
    step(3'b111, 3, 1'b1);
    step(3'b111, 0, 1'b0);
    do_reset();
    step(3'b111, 0, 1'b1);
    step(3'b000, 0, 1'b1);
    repeat (400) begin
      for (int i = 0; i < N; i++) dat[i] = {$urandom, $urandom, $urandom, $urandom};
      step(N'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    repeat (3) step(3'b000, 0, 1'b1);
    chk("drain_empty", CW'(q.size()), CW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
